// File: rtl/autoplay_led_note_hold_if.sv
// rtl/autoplay_led_note_hold_if.sv - note/mute in, LED outputs bundle between sequencer and LED driver
interface autoplay_led_note_hold_if #(
  parameter int NOTE_W   = 5,
  parameter int NUM_LEDS = 7
);
  logic [NOTE_W-1:0]   note;
  logic                mute;
  logic [NUM_LEDS-1:0] led;
  logic                led_any;

  modport master (
    output note,
    output mute,
    input  led,
    input  led_any
  );

  modport slave (
    input  note,
    input  mute,
    output led,
    output led_any
  );
endinterface

// File: rtl/autoplay_led_note_hold.sv
// rtl/autoplay_led_note_hold.sv - per-note LED driver with post-release hold; LED_FADE_EN adds PWM fade during hold
module autoplay_led_note_hold #(
  parameter int NOTE_W     = 5,
  parameter int NUM_LEDS   = 7,
  parameter int TICK_DIV   = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic clk,
  input  logic rst_n,
  autoplay_led_note_hold_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q [NUM_LEDS];
  state_t              state_d [NUM_LEDS];
  logic [HW-1:0]       cnt_q   [NUM_LEDS];
  logic [HW-1:0]       cnt_d   [NUM_LEDS];
  logic [PW-1:0]       pre_q;
  logic                tick;
  logic [NUM_LEDS-1:0] hit;
  logic [NUM_LEDS-1:0] led_d;
  logic [NUM_LEDS-1:0] led_q;
  logic                led_any_q;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      hit[i] = (bus.note == NOTE_W'(i + 1));
    end
  end

`ifdef LED_FADE_EN
  logic [HW-1:0] pwm_q;
  logic [HW-1:0] pwm_d;

  assign pwm_d = (pwm_q == HW'(HOLD_TICKS - 1)) ? '0 : pwm_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      led_d[i]   = 1'b0;
      if (bus.mute) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (hit[i]) state_d[i] = ON;
          end
          ON: begin
            if (!hit[i]) begin
              state_d[i] = HOLD;
              cnt_d[i]   = HW'(HOLD_TICKS);
            end
          end
          HOLD: begin
            // A hit in a tick cycle retriggers rather than counting down.
            if (hit[i]) begin
              state_d[i] = ON;
            end else if (tick) begin
              cnt_d[i] = cnt_q[i] - 1'b1;
              if (cnt_q[i] == HW'(1)) state_d[i] = IDLE;
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      case (state_d[i])
        ON:      led_d[i] = 1'b1;
`ifdef LED_FADE_EN
        HOLD:    led_d[i] = (pwm_d < cnt_d[i]);
`else
        HOLD:    led_d[i] = 1'b1;
`endif
        default: led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q     <= '0;
      led_q     <= '0;
      led_any_q <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      pre_q     <= tick ? '0 : pre_q + 1'b1;
      led_q     <= led_d;
      led_any_q <= |led_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.led     = led_q;
  assign bus.led_any = led_any_q;
endmodule
